// File: rtl/logo_bounce_sequencer_if.sv
// Bundle between the frame timing source and the logo bounce sequencer.
// The master drives the frame strobe and motion controls; the slave returns the committed origin.
interface logo_bounce_sequencer_if;
  logic       frame_tick;
  logic       run;
  logic [1:0] speed;
  logic [9:0] org_x;
  logic [9:0] org_y;
  logic [1:0] palette;
  logic       corner_flash;
  logic       frame_done;
  logic       busy;

  modport master (
    output frame_tick, run, speed,
    input  org_x, org_y, palette, corner_flash, frame_done, busy
  );

  modport slave (
    input  frame_tick, run, speed,
    output org_x, org_y, palette, corner_flash, frame_done, busy
  );
endinterface

// File: rtl/logo_bounce_sequencer.sv
// Frame-rate controller that bounces the logo origin and steps the palette on wall hits.
// New position is computed in shadow registers and committed once per frame during blanking.
module logo_bounce_sequencer #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BOX_W        = 240,
  parameter int unsigned BOX_H        = 240,
  parameter int unsigned X_INIT       = 200,
  parameter int unsigned Y_INIT       = 120,
  parameter int unsigned FRAME_DIV    = 1,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input logic                     clk,
  input logic                     reset,
  logo_bounce_sequencer_if.slave  bus
);

  localparam int unsigned X_MAX  = H_ACTIVE - BOX_W;
  localparam int unsigned Y_MAX  = V_ACTIVE - BOX_H;
  localparam int unsigned DivW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned FlashW = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;

  localparam logic [10:0]       XMax      = 11'(X_MAX);
  localparam logic [10:0]       YMax      = 11'(Y_MAX);
  localparam logic [9:0]        XInit     = 10'(X_INIT);
  localparam logic [9:0]        YInit     = 10'(Y_INIT);
  localparam logic [DivW-1:0]   DivLast   = DivW'(FRAME_DIV - 1);
  localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_FRAMES);

  typedef enum logic [1:0] {
    StIdle,
    StUpdX,
    StUpdY,
    StCommit
  } state_e;

  state_e            state_q, state_d;
  logic              tick_q, tick_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              step_q, step_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              dir_x_neg_q, dir_x_neg_d;
  logic              dir_y_neg_q, dir_y_neg_d;
  logic              hit_x_q, hit_x_d;
  logic              hit_y_q, hit_y_d;
  logic [9:0]        org_x_q, org_x_d;
  logic [9:0]        org_y_q, org_y_d;
  logic [1:0]        palette_q, palette_d;
  logic [FlashW-1:0] flash_q, flash_d;
  logic              done_q, done_d;
  logic [10:0]       step_size;

  // Returns {hit, dir_neg, pos}; clamps to the wall instead of wrapping.
  function automatic logic [11:0] bounce(input logic [9:0]  pos,
                                         input logic        neg,
                                         input logic [10:0] s,
                                         input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (!neg) begin
      if (p + s >= lim) bounce = {1'b1, 1'b1, lim[9:0]};
      else              bounce = {1'b0, 1'b0, 10'(p + s)};
    end else begin
      if (p <= s)       bounce = {1'b1, 1'b0, 10'd0};
      else              bounce = {1'b0, 1'b1, 10'(p - s)};
    end
  endfunction

  assign step_size = {9'd0, bus.speed} + 11'd1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    step_d      = step_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_neg_d = dir_x_neg_q;
    dir_y_neg_d = dir_y_neg_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    org_x_d     = org_x_q;
    org_y_d     = org_y_q;
    palette_d   = palette_q;
    flash_d     = flash_q;
    done_d      = 1'b0;
    // Strobe is registered once; anything arriving while a frame is pending or running is dropped.
    tick_d      = bus.frame_tick & (state_q == StIdle) & ~tick_q;

    unique case (state_q)
      StIdle: begin
        if (tick_q) state_d = StUpdX;
      end
      StUpdX: begin
        state_d = StUpdY;
        step_d  = bus.run && (div_q == DivLast);
        if (bus.run) begin
          div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
        end
        if (step_d) begin
          {hit_x_d, dir_x_neg_d, x_d} = bounce(x_q, dir_x_neg_q, step_size, XMax);
        end
      end
      StUpdY: begin
        state_d = StCommit;
        if (step_q) begin
          {hit_y_d, dir_y_neg_d, y_d} = bounce(y_q, dir_y_neg_q, step_size, YMax);
        end
      end
      StCommit: begin
        state_d = StIdle;
        org_x_d = x_q;
        org_y_d = y_q;
        done_d  = 1'b1;
        if (hit_x_q || hit_y_q) palette_d = palette_q + 2'd1;
        if (hit_x_q && hit_y_q) begin
          flash_d = FlashLoad;
        end else if (flash_q != '0) begin
          flash_d = flash_q - FlashW'(1);
        end
        hit_x_d = 1'b0;
        hit_y_d = 1'b0;
        step_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tick_q      <= 1'b0;
      div_q       <= '0;
      step_q      <= 1'b0;
      x_q         <= XInit;
      y_q         <= YInit;
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
      org_x_q     <= XInit;
      org_y_q     <= YInit;
      palette_q   <= 2'd0;
      flash_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      div_q       <= div_d;
      step_q      <= step_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_neg_q <= dir_x_neg_d;
      dir_y_neg_q <= dir_y_neg_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      org_x_q     <= org_x_d;
      org_y_q     <= org_y_d;
      palette_q   <= palette_d;
      flash_q     <= flash_d;
      done_q      <= done_d;
    end
  end

  assign bus.org_x        = org_x_q;
  assign bus.org_y        = org_y_q;
  assign bus.palette      = palette_q;
  assign bus.corner_flash = (flash_q != '0);
  assign bus.frame_done   = done_q;
  assign bus.busy         = (state_q != StIdle);

endmodule
